// File: rtl/gf180mcu_rr_arb4.sv
// -----------------------------------------------------------------------------
// gf180mcu_rr_arb4
//   Clocked four-way round-robin arbiter for a shared resource.
//   The grant is registered and delivered both one-hot and encoded. A hold
//   limit stops one requester from keeping the resource forever while others
//   wait. Dropping the holder's request re-arbitrates on the same edge, so no
//   idle cycle appears between back-to-back owners.
//
// Parameters
//   HOLD_MAX : maximum consecutive grant cycles while others wait (0 = no limit)
//   CW       : hold-counter width, 2**CW must exceed HOLD_MAX
//
// Ports
//   VDD, VSS : supply pins, present only with USE_POWER_PINS, no logic function
//   CLK      : rising-edge clock
//   RN       : asynchronous active-low reset
//   REQ[3:0] : level request lines, bit i belongs to requester i
//   ANY      : combinational OR of REQ
//   GNT[3:0] : registered one-hot grant, all zero when idle
//   GNT_VLD  : registered, high when any GNT bit is high
//   GNT_ID   : registered index of the granted requester, 0 when idle
// -----------------------------------------------------------------------------
module gf180mcu_rr_arb4 #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 8
) (
`ifdef USE_POWER_PINS
  inout  wire        VDD,
  inout  wire        VSS,
`endif
  input  logic       CLK,
  input  logic       RN,
  input  logic [3:0] REQ,
  output logic       ANY,
  output logic [3:0] GNT,
  output logic       GNT_VLD,
  output logic [1:0] GNT_ID
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_BUSY  = 1'b1;
  localparam logic          HOLD_EN  = (HOLD_MAX != 0);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Without a hold limit the counter simply parks at its all-ones value.
  localparam logic [CW-1:0] CNT_SAT  = HOLD_EN ? HOLD_LIM : {CW{1'b1}};

  // First set request bit scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] f_win(input logic [1:0] p, input logic [3:0] req);
    logic [1:0] idx;
    f_win = p;
    // Scan from the far end so the nearest set bit is the last one written.
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (req[idx]) begin
        f_win = idx;
      end else begin
        f_win = f_win;
      end
    end
  endfunction

  function automatic logic [3:0] f_onehot(input logic [1:0] i);
    f_onehot = 4'b0001 << i;
  endfunction

  logic [0:0]    r_state;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_gnt;
  logic          r_gnt_vld;
  logic [1:0]    r_gnt_id;

  logic          w_any;
  logic [1:0]    w_win;
  logic [1:0]    w_rot;
  logic          w_hold;
  logic          w_others;
  logic          w_grant;
  logic          w_clear;
  logic [1:0]    w_sel;
  logic [0:0]    w_state_nxt;
  logic [1:0]    w_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_gnt_nxt;
  logic          w_vld_nxt;
  logic [1:0]    w_id_nxt;

  assign w_any    = |REQ;
  assign ANY      = w_any;
  assign w_win    = f_win(r_ptr, REQ);
  // Forced rotation starts after the holder and never picks the holder itself.
  assign w_rot    = f_win(r_gnt_id + 2'd1, REQ & ~f_onehot(r_gnt_id));
  assign w_hold   = REQ[r_gnt_id];
  assign w_others = |(REQ & ~f_onehot(r_gnt_id));

  // Arbitration decision: new grant, return to idle, or keep the current owner.
  always_comb begin
    w_grant = 1'b0;
    w_clear = 1'b0;
    w_sel   = w_win;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
        end else begin
          w_clear = 1'b1;
        end
      end
      ST_BUSY: begin
        // Release is checked first, so it beats the hold limit in the same cycle.
        if (!w_hold) begin
          if (w_any) begin
            w_grant = 1'b1;
          end else begin
            w_clear = 1'b1;
          end
        end else if (HOLD_EN && (r_cnt == HOLD_LIM) && w_others) begin
          w_grant = 1'b1;
          w_sel   = w_rot;
        end else begin
          w_grant = 1'b0;
          w_clear = 1'b0;
        end
      end
      default: begin
        w_clear = 1'b1;
      end
    endcase
  end

  // Next register values for the chosen action.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_vld_nxt   = r_gnt_vld;
    w_id_nxt    = r_gnt_id;
    if (w_grant) begin
      w_state_nxt = ST_BUSY;
      w_ptr_nxt   = w_sel + 2'd1;
      w_cnt_nxt   = CNT_ONE;
      w_gnt_nxt   = f_onehot(w_sel);
      w_vld_nxt   = 1'b1;
      w_id_nxt    = w_sel;
    end else if (w_clear) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = {CW{1'b0}};
      w_gnt_nxt   = 4'b0000;
      w_vld_nxt   = 1'b0;
      w_id_nxt    = 2'd0;
    end else begin
      if (r_cnt < CNT_SAT) begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end else begin
        w_cnt_nxt = CNT_SAT;
      end
    end
  end

  // State, pointer, counter and grant outputs; reset clears all immediately.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_cnt     <= {CW{1'b0}};
      r_gnt     <= 4'b0000;
      r_gnt_vld <= 1'b0;
      r_gnt_id  <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= w_vld_nxt;
      r_gnt_id  <= w_id_nxt;
    end
  end

  assign GNT     = r_gnt;
  assign GNT_VLD = r_gnt_vld;
  assign GNT_ID  = r_gnt_id;

endmodule

// File: tb/tb_gf180mcu_rr_arb4.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_rr_arb4
//   Directed bench for the four-way round-robin arbiter with HOLD_MAX=3.
//   Inputs change just after a falling edge; outputs are checked on the
//   falling edge, i.e. half a cycle after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_gf180mcu_rr_arb4;

  logic       CLK;
  logic       RN;
  logic [3:0] REQ;
  logic       ANY;
  logic [3:0] GNT;
  logic       GNT_VLD;
  logic [1:0] GNT_ID;

  int n_checks;
  int n_errors;

  gf180mcu_rr_arb4 #(.HOLD_MAX(3), .CW(8)) dut (
    .CLK     (CLK),
    .RN      (RN),
    .REQ     (REQ),
    .ANY     (ANY),
    .GNT     (GNT),
    .GNT_VLD (GNT_VLD),
    .GNT_ID  (GNT_ID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare the three grant outputs against one expected grant vector.
  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eid);
    logic ev;
    ev = |eg;
    n_checks++;
    assert (GNT === eg) else begin
      n_errors++;
      $error("FAIL %s GNT: got %b expected %b", tag, GNT, eg);
    end
    n_checks++;
    assert (GNT_VLD === ev) else begin
      n_errors++;
      $error("FAIL %s GNT_VLD: got %b expected %b", tag, GNT_VLD, ev);
    end
    n_checks++;
    assert (GNT_ID === eid) else begin
      n_errors++;
      $error("FAIL %s GNT_ID: got %0d expected %0d", tag, GNT_ID, eid);
    end
  endtask

  task automatic chk_any(input string tag, input logic ea);
    n_checks++;
    assert (ANY === ea) else begin
      n_errors++;
      $error("FAIL %s ANY: got %b expected %b", tag, ANY, ea);
    end
  endtask

  // Reset pulse between rising edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    @(negedge CLK);
    REQ = 4'b0000;
    RN  = 1'b0;
    #2;
    chk(tag, 4'b0000, 2'd0);
    RN = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RN  = 1'b0;
    REQ = 4'b0000;

    // ANY keeps following REQ during reset while grants stay cleared.
    #7;
    REQ = 4'b0101;
    #1;
    chk_any("rst_any_hi", 1'b1);
    chk("rst_hold", 4'b0000, 2'd0);
    REQ = 4'b0000;
    #1;
    chk_any("rst_any_lo", 1'b0);

    // Idle: no requests for 5 cycles.
    @(negedge CLK);
    RN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("idle", 4'b0000, 2'd0);
      chk_any("idle_any", 1'b0);
    end

    // All four request; each holder drops one cycle after its grant.
    REQ = 4'b1111;
    @(negedge CLK);
    chk("rr_g0", 4'b0001, 2'd0);
    chk_any("rr_any", 1'b1);
    REQ = 4'b1110;
    @(negedge CLK);
    chk("rr_g1", 4'b0010, 2'd1);
    REQ = 4'b1100;
    @(negedge CLK);
    chk("rr_g2", 4'b0100, 2'd2);
    REQ = 4'b1000;
    @(negedge CLK);
    chk("rr_g3", 4'b1000, 2'd3);
    REQ = 4'b0001;
    @(negedge CLK);
    chk("rr_g0b", 4'b0001, 2'd0);
    REQ = 4'b0000;
    @(negedge CLK);
    chk("rr_idle", 4'b0000, 2'd0);

    // Hold limit 3 with two constant requesters: 0,0,0,1,1,1,0.
    pulse_reset("rst_a");
    REQ = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("lim_g0", 4'b0001, 2'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("lim_g1", 4'b0010, 2'd1);
    end
    @(negedge CLK);
    chk("lim_back0", 4'b0001, 2'd0);

    // Lone requester 2 is never forced off, then releases to idle.
    pulse_reset("rst_b");
    REQ = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("lone", 4'b0100, 2'd2);
    end
    REQ = 4'b0000;
    @(negedge CLK);
    chk("lone_rel", 4'b0000, 2'd0);

    // Holder 2 reaches the limit and releases with 0 and 3 pending (ptr=3).
    pulse_reset("rst_c");
    REQ = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("pre_rel", 4'b0100, 2'd2);
    end
    REQ = 4'b1001;
    @(negedge CLK);
    chk("rel_win3", 4'b1000, 2'd3);
    REQ = 4'b0001;
    @(negedge CLK);
    chk("rel_ptr0", 4'b0001, 2'd0);

    // Mid-cycle reset while requester 1 holds; pointer must restart at 0.
    pulse_reset("rst_d");
    REQ = 4'b0010;
    @(negedge CLK);
    chk("pre_rst", 4'b0010, 2'd1);
    #2;
    RN = 1'b0;
    #1;
    chk("async_rst", 4'b0000, 2'd0);
    RN  = 1'b1;
    REQ = 4'b0110;
    @(negedge CLK);
    chk("post_rst", 4'b0010, 2'd1);

    REQ = 4'b0000;
    @(negedge CLK);
    chk("end_idle", 4'b0000, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
